// File: rtl/ctrl_pipeline.sv
// Control and hazard unit for a 5-stage in-order pipeline.
// It tracks EX/MEM/WB control state, detects load-use stalls and taken-branch flushes, and selects forwarding sources.
module ctrl_pipeline #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             RegRead,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             RegDst,
  input  logic             Branch,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             branch_taken,
  output logic             stall,
  output logic             flush,
  output logic             ex_valid,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_Branch,
  output logic [4:0]       ex_dest,
  output logic             mem_valid,
  output logic             mem_RegWrite,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic [4:0]       mem_dest,
  output logic             wb_valid,
  output logic             wb_RegWrite,
  output logic [4:0]       wb_dest,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] id_dest;
  logic       load_use;
  logic       ex_take;
  logic       mem_fwd_ok;
  logic       wb_fwd_ok;

  // MEM beats WB; a zero destination is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       mem_ok,
                                         input logic [4:0] mdest,
                                         input logic       wb_ok,
                                         input logic [4:0] wdest);
    if (mem_ok && (mdest == src))     return 2'b10;
    else if (wb_ok && (wdest == src)) return 2'b01;
    else                              return 2'b00;
  endfunction

  always_comb begin
    id_dest  = RegDst ? id_rd : id_rt;
    flush    = ex_valid & ex_Branch & branch_taken;
    load_use = ex_valid & ex_MemRead & (ex_dest != 5'd0) & id_valid & RegRead &
               ((ex_dest == id_rs) | (ex_dest == id_rt));
    stall    = load_use & ~flush;
    ex_take  = id_valid & ~stall & ~flush;
  end

  always_comb begin
    // A load in MEM has no data yet, so it is not a forwarding source.
    mem_fwd_ok = mem_valid & mem_RegWrite & ~mem_MemRead & (mem_dest != 5'd0);
    wb_fwd_ok  = wb_valid & wb_RegWrite & (wb_dest != 5'd0);
    fwd_a      = fwd_sel(ex_rs, mem_fwd_ok, mem_dest, wb_fwd_ok, wb_dest);
    fwd_b      = fwd_sel(ex_rt, mem_fwd_ok, mem_dest, wb_fwd_ok, wb_dest);
  end

  // NOTE: state registers use non-blocking assignments so every stage samples the
  // previous stage's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (reset || !ex_take) begin
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_dest     <= 5'd0;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
    end else begin
      ex_valid    <= 1'b1;
      ex_RegWrite <= RegWrite;
      ex_MemRead  <= MemRead;
      ex_MemWrite <= MemWrite;
      ex_Branch   <= Branch;
      ex_dest     <= id_dest;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid    <= 1'b0;
      mem_RegWrite <= 1'b0;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      mem_dest     <= 5'd0;
      wb_valid     <= 1'b0;
      wb_RegWrite  <= 1'b0;
      wb_dest      <= 5'd0;
    end else begin
      mem_valid    <= ex_valid;
      mem_RegWrite <= ex_RegWrite;
      mem_MemRead  <= ex_MemRead;
      mem_MemWrite <= ex_MemWrite;
      mem_dest     <= ex_dest;
      wb_valid     <= mem_valid;
      wb_RegWrite  <= mem_RegWrite;
      wb_dest      <= mem_dest;
    end
  end

  // Saturating event counters; reset wins over a same-cycle stall or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed vector table, corner-case sequences and random stimulus
// against an instruction-level pipeline model; a second instance with CNT_W=2 exercises saturation.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       idv, rr, rw, mr, mw, rdst, br, bt;
    logic [4:0] rs, rt, rd;
  } in_t;

  typedef struct packed {
    logic       v, rw, mr, mw, br;
    logic [4:0] dest, rs, rt;
  } inst_t;

  typedef struct {
    in_t        in;
    logic       s, f;
    logic [1:0] fa, fb;
    logic       exv;
    int         scnt, fcnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, RegRead, RegWrite, MemRead, MemWrite, RegDst, Branch, branch_taken;
  logic [4:0] id_rs, id_rt, id_rd;

  logic stall, flush, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
  logic mem_valid, mem_RegWrite, mem_MemRead, mem_MemWrite, wb_valid, wb_RegWrite;
  logic [4:0] ex_dest, mem_dest, wb_dest;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic s2_stall, s2_flush, s2_ex_valid, s2_ex_RegWrite, s2_ex_MemRead, s2_ex_MemWrite, s2_ex_Branch;
  logic s2_mem_valid, s2_mem_RegWrite, s2_mem_MemRead, s2_mem_MemWrite, s2_wb_valid, s2_wb_RegWrite;
  logic [4:0] s2_ex_dest, s2_mem_dest, s2_wb_dest;
  logic [1:0] s2_fwd_a, s2_fwd_b;
  logic [1:0] s2_stall_cnt, s2_flush_cnt;

  ctrl_pipeline dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .RegRead(RegRead), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst), .Branch(Branch),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_dest(ex_dest),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_dest(mem_dest), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ctrl_pipeline #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .RegRead(RegRead), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst), .Branch(Branch),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_taken(branch_taken),
    .stall(s2_stall), .flush(s2_flush), .ex_valid(s2_ex_valid), .ex_RegWrite(s2_ex_RegWrite),
    .ex_MemRead(s2_ex_MemRead), .ex_MemWrite(s2_ex_MemWrite), .ex_Branch(s2_ex_Branch),
    .ex_dest(s2_ex_dest), .mem_valid(s2_mem_valid), .mem_RegWrite(s2_mem_RegWrite),
    .mem_MemRead(s2_mem_MemRead), .mem_MemWrite(s2_mem_MemWrite), .mem_dest(s2_mem_dest),
    .wb_valid(s2_wb_valid), .wb_RegWrite(s2_wb_RegWrite), .wb_dest(s2_wb_dest),
    .fwd_a(s2_fwd_a), .fwd_b(s2_fwd_b), .stall_cnt(s2_stall_cnt), .flush_cnt(s2_flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB; raw event counts.
  inst_t pipe [3];
  int    raw_s, raw_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Youngest producer of src among MEM (non-load) then WB; r0 is never produced.
  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (pipe[1].v && pipe[1].rw && !pipe[1].mr && pipe[1].dest == src) return 2'b10;
    if (pipe[2].v && pipe[2].rw && pipe[2].dest == src) return 2'b01;
    return 2'b00;
  endfunction

  // c = {idv, rr, rw, mr, rdst, br, bt}
  function automatic in_t mk(input logic [6:0] c, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
    in_t i;
    {i.idv, i.rr, i.rw, i.mr, i.rdst, i.br, i.bt} = c;
    i.mw = 1'b0;
    i.rs = rs;
    i.rt = rt;
    i.rd = rd;
    return i;
  endfunction

  function automatic vec_t mv(input in_t i, input logic [1:0] sf, input logic [1:0] fa,
                              input logic [1:0] fb, input logic exv, input int sc, input int fc);
    vec_t v;
    v.in   = i;
    v.s    = sf[1];
    v.f    = sf[0];
    v.fa   = fa;
    v.fb   = fb;
    v.exv  = exv;
    v.scnt = sc;
    v.fcnt = fc;
    return v;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, clock, check registered state.
  task automatic step(input logic r, input in_t i, output logic ds, output logic df,
                      output logic [1:0] dfa, output logic [1:0] dfb);
    logic  ms, mf;
    inst_t ni;
    @(negedge clk);
    reset = r; id_valid = i.idv; RegRead = i.rr; RegWrite = i.rw; MemRead = i.mr;
    MemWrite = i.mw; RegDst = i.rdst; Branch = i.br; branch_taken = i.bt;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    #1;
    mf = pipe[0].v && pipe[0].br && i.bt;
    ms = !mf && pipe[0].v && pipe[0].mr && pipe[0].dest != 5'd0 && i.idv && i.rr &&
         (pipe[0].dest == i.rs || pipe[0].dest == i.rt);
    ds = stall; df = flush; dfa = fwd_a; dfb = fwd_b;
    check("stall", 32'(stall), 32'(ms));
    check("flush", 32'(flush), 32'(mf));
    check("fwd_a", 32'(fwd_a), 32'(m_fwd(pipe[0].rs)));
    check("fwd_b", 32'(fwd_b), 32'(m_fwd(pipe[0].rt)));
    check("stall_w2", 32'(s2_stall), 32'(ms));
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      raw_s = 0;
      raw_f = 0;
    end else begin
      ni = '0;
      if (i.idv && !ms && !mf) ni = '{1'b1, i.rw, i.mr, i.mw, i.br, (i.rdst ? i.rd : i.rt), i.rs, i.rt};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = ni;
      raw_s += int'(ms);
      raw_f += int'(mf);
    end
    #1;
    check("ex_stage", 32'({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_dest}),
          32'({pipe[0].v, pipe[0].rw, pipe[0].mr, pipe[0].mw, pipe[0].br, pipe[0].dest}));
    check("mem_stage", 32'({mem_valid, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_dest}),
          32'({pipe[1].v, pipe[1].rw, pipe[1].mr, pipe[1].mw, pipe[1].dest}));
    check("wb_stage", 32'({wb_valid, wb_RegWrite, wb_dest}),
          32'({pipe[2].v, pipe[2].rw, pipe[2].dest}));
    check("stall_cnt", 32'(stall_cnt), 32'(sat(raw_s, 16)));
    check("flush_cnt", 32'(flush_cnt), 32'(sat(raw_f, 16)));
    check("stall_cnt_w2", 32'(s2_stall_cnt), 32'(sat(raw_s, 2)));
    check("flush_cnt_w2", 32'(s2_flush_cnt), 32'(sat(raw_f, 2)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tv [16];
    in_t        nop, load5, use5, ri;
    logic       ds, df;
    logic [1:0] dfa, dfb;
    logic       rr;

    nop   = mk(7'b0000000, 5'd0, 5'd0, 5'd0);
    load5 = mk(7'b1111000, 5'd1, 5'd5, 5'd0);
    use5  = mk(7'b1110100, 5'd5, 5'd6, 5'd7);
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    raw_s = 0;
    raw_f = 0;

    // Load-use stall, then forward from WB once the consumer reaches EX.
    tv[0]  = mv(load5,                                   2'b00, 2'b00, 2'b00, 1'b1, 0, 0);
    tv[1]  = mv(use5,                                    2'b10, 2'b00, 2'b00, 1'b0, 1, 0);
    tv[2]  = mv(use5,                                    2'b00, 2'b00, 2'b00, 1'b1, 1, 0);
    tv[3]  = mv(nop,                                     2'b00, 2'b01, 2'b00, 1'b0, 1, 0);
    // Back-to-back ALU dependency on r3 through MEM.
    tv[4]  = mv(mk(7'b1110100, 5'd1, 5'd2, 5'd3),        2'b00, 2'b00, 2'b00, 1'b1, 1, 0);
    tv[5]  = mv(mk(7'b1110100, 5'd3, 5'd3, 5'd8),        2'b00, 2'b00, 2'b00, 1'b1, 1, 0);
    tv[6]  = mv(nop,                                     2'b00, 2'b10, 2'b10, 1'b0, 1, 0);
    // Two writers of r4 in MEM and WB: MEM wins.
    tv[7]  = mv(mk(7'b1010100, 5'd0, 5'd0, 5'd4),        2'b00, 2'b00, 2'b00, 1'b1, 1, 0);
    tv[8]  = mv(mk(7'b1010100, 5'd0, 5'd0, 5'd4),        2'b00, 2'b00, 2'b00, 1'b1, 1, 0);
    tv[9]  = mv(mk(7'b1110100, 5'd4, 5'd9, 5'd10),       2'b00, 2'b00, 2'b00, 1'b1, 1, 0);
    tv[10] = mv(nop,                                     2'b00, 2'b10, 2'b00, 1'b0, 1, 0);
    // Taken branch that is also a load-use producer: flush wins.
    tv[11] = mv(mk(7'b1111010, 5'd2, 5'd5, 5'd0),        2'b00, 2'b00, 2'b00, 1'b1, 1, 0);
    tv[12] = mv(mk(7'b1110101, 5'd5, 5'd6, 5'd7),        2'b01, 2'b00, 2'b00, 1'b0, 1, 1);
    // Load to r0 then use of r0: no stall, no forwarding.
    tv[13] = mv(mk(7'b1111000, 5'd0, 5'd0, 5'd0),        2'b00, 2'b00, 2'b00, 1'b1, 1, 1);
    tv[14] = mv(mk(7'b1110100, 5'd0, 5'd0, 5'd1),        2'b00, 2'b00, 2'b00, 1'b1, 1, 1);
    tv[15] = mv(nop,                                     2'b00, 2'b00, 2'b00, 1'b0, 1, 1);

    step(1'b1, nop, ds, df, dfa, dfb);
    step(1'b1, nop, ds, df, dfa, dfb);
    check("reset_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
    check("reset_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);

    for (int k = 0; k < 16; k++) begin
      step(1'b0, tv[k].in, ds, df, dfa, dfb);
      check($sformatf("v%0d_stall", k), 32'(ds), 32'(tv[k].s));
      check($sformatf("v%0d_flush", k), 32'(df), 32'(tv[k].f));
      check($sformatf("v%0d_fwd_a", k), 32'(dfa), 32'(tv[k].fa));
      check($sformatf("v%0d_fwd_b", k), 32'(dfb), 32'(tv[k].fb));
      check($sformatf("v%0d_ex_valid", k), 32'(ex_valid), 32'(tv[k].exv));
      check($sformatf("v%0d_stall_cnt", k), 32'(stall_cnt), 32'(tv[k].scnt));
      check($sformatf("v%0d_flush_cnt", k), 32'(flush_cnt), 32'(tv[k].fcnt));
    end

    // Five load-use stalls: 2-bit counter sticks at 3.
    step(1'b1, nop, ds, df, dfa, dfb);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, load5, ds, df, dfa, dfb);
      step(1'b0, use5, ds, df, dfa, dfb);
    end
    check("sat_stall_cnt_w2", 32'(s2_stall_cnt), 32'd3);
    check("sat_stall_cnt", 32'(stall_cnt), 32'd5);

    // Reset with every stage valid and a load-use hazard pending.
    step(1'b0, mk(7'b1010100, 5'd1, 5'd2, 5'd3), ds, df, dfa, dfb);
    step(1'b0, mk(7'b1010100, 5'd2, 5'd3, 5'd4), ds, df, dfa, dfb);
    step(1'b0, load5, ds, df, dfa, dfb);
    check("mid_full", 32'({ex_valid, mem_valid, wb_valid}), 32'd7);
    step(1'b1, use5, ds, df, dfa, dfb);
    check("mid_stall_seen", 32'(ds), 32'd1);
    check("mid_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
    check("mid_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    check("mid_cnts_w2", 32'({s2_stall_cnt, s2_flush_cnt}), 32'd0);
    step(1'b0, nop, ds, df, dfa, dfb);
    check("post_reset_comb", 32'({ds, df, dfa, dfb}), 32'd0);

    for (int k = 0; k < 400; k++) begin
      ri.idv  = ($urandom_range(0, 3) != 0);
      ri.rr   = 1'($urandom);
      ri.rw   = 1'($urandom);
      ri.mr   = 1'($urandom);
      ri.mw   = 1'($urandom);
      ri.rdst = 1'($urandom);
      ri.br   = ($urandom_range(0, 3) == 0);
      ri.bt   = 1'($urandom);
      ri.rs   = 5'($urandom_range(0, 7));
      ri.rt   = 5'($urandom_range(0, 7));
      ri.rd   = 5'($urandom_range(0, 7));
      rr      = ($urandom_range(0, 59) == 0);
      step(rr, ri, ds, df, dfa, dfb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
